// File: rtl/sdfm_pkg.sv
// Shared constants and arbiter state encoding for the sigma-delta result arbiter.
package sdfm_pkg;

    localparam int unsigned SdfmNch = 4;
    localparam int unsigned SdfmDw  = 32;

    typedef enum logic {
        StIdle  = 1'b0,
        StOffer = 1'b1
    } arb_state_e;

    // Channel index width; never below one bit so a 1-wide index always exists.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sdfm_rr_pick.sv
// Round-robin pick: first requesting index after ptr_i, wrapping at NCH-1.
module sdfm_rr_pick
    import sdfm_pkg::*;
#(
    parameter int unsigned NCH = SdfmNch,
    parameter int unsigned CW  = idx_width(NCH)
) (
    input  logic [NCH-1:0] req_i,
    input  logic [CW-1:0]  ptr_i,
    output logic [CW-1:0]  gnt_o,
    output logic           any_o
);

    logic [CW-1:0] idx;

    always_comb begin
        gnt_o = '0;
        any_o = 1'b0;
        idx   = '0;
        for (int unsigned k = 1; k <= NCH; k++) begin
            idx = CW'((32'(ptr_i) + k) % NCH);
            if (!any_o && req_i[idx]) begin
                gnt_o = idx;
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdfm_result_arb.sv
// Collects per-channel filter results into holding registers and offers them
// one at a time on a valid/ready port in round-robin order.
module sdfm_result_arb
    import sdfm_pkg::*;
#(
    parameter  int unsigned NCH = SdfmNch,
    parameter  int unsigned DW  = SdfmDw,
    localparam int unsigned CW  = idx_width(NCH)
) (
    input  logic              SYSCLK,
    input  logic              SYSRSTn,
    input  logic [NCH*DW-1:0] ch_data,
    input  logic [NCH-1:0]    ch_update,
    input  logic [NCH-1:0]    ch_en,
    output logic [DW-1:0]     out_data,
    output logic [CW-1:0]     out_ch,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NCH-1:0]    pend,
    output logic [NCH-1:0]    ovf,
    input  logic [NCH-1:0]    ovf_clr,
    output logic              irq
);

    arb_state_e    state_q, state_d;
    logic [DW-1:0] hold_q [NCH];
    logic [DW-1:0] hold_d [NCH];
    logic [NCH-1:0] pend_q, pend_d, ovf_q, ovf_d;
    logic [NCH-1:0] cap, gnt_oh, req;
    logic           irq_q;
    logic [DW-1:0]  out_data_q, out_data_d;
    logic [CW-1:0]  out_ch_q, out_ch_d, ptr_q, ptr_d, pick;
    logic           out_valid_q, out_valid_d, pick_any, grant;

    // A disabled channel is never granted, even if its pend bit is still set this cycle.
    assign req = pend_q & ch_en;

    sdfm_rr_pick #(
        .NCH (NCH),
        .CW  (CW)
    ) u_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (pick),
        .any_o (pick_any)
    );

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        grant       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pick_any) begin
                    grant       = 1'b1;
                    out_data_d  = hold_q[pick];
                    out_ch_d    = pick;
                    out_valid_d = 1'b1;
                    state_d     = StOffer;
                end
            end
            StOffer: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    ptr_d       = out_ch_q;
                    state_d     = StIdle;
                end
            end
        endcase
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            cap[i]    = ch_update[i] & ch_en[i];
            gnt_oh[i] = grant && (pick == CW'(i));
            hold_d[i] = cap[i] ? ch_data[i*DW +: DW] : hold_q[i];
            // A capture on the grant edge refills the slot rather than overrunning it.
            pend_d[i] = ch_en[i] & (cap[i] | (pend_q[i] & ~gnt_oh[i]));
            ovf_d[i]  = (cap[i] & pend_q[i] & ~gnt_oh[i]) | (ovf_q[i] & ~ovf_clr[i]);
        end
    end

    always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
        if (!SYSRSTn) begin
            state_q     <= StIdle;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= CW'(NCH - 1);
            pend_q      <= '0;
            ovf_q       <= '0;
            irq_q       <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
            pend_q      <= pend_d;
            ovf_q       <= ovf_d;
            irq_q       <= |ovf_q;
            for (int i = 0; i < NCH; i++) begin
                hold_q[i] <= hold_d[i];
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;
    assign pend      = pend_q;
    assign ovf       = ovf_q;
    assign irq       = irq_q;

endmodule
